uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rr_pick.sv | 39 +++
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and limits for the UART transmit arbiter.
// Tag insertion in the arbiter is enabled by defining UART_ARB_TAG_EN.
package uart_pkg;

    localparam int UART_ARB_MAX_NREQ = 8;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ARB_IDLE = 2'd0;
    localparam arb_state_t ARB_TAG  = 2'd1;
    localparam arb_state_t ARB_DATA = 2'd2;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first requester after last_grant, wrapping modulo NREQ.
// Independent of UART_ARB_TAG_EN.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last_grant,
    output logic [$clog2(NREQ)-1:0] grant,
    output logic                    any_req
);

    localparam int GW = $clog2(NREQ);

    logic          w_hit_hi;
    logic [GW-1:0] w_grant_hi;
    logic [GW-1:0] w_grant_lo;

    // Descending scan so the lowest qualifying index is the one left standing.
    always_comb begin
        w_hit_hi   = 1'b0;
        w_grant_hi = '0;
        w_grant_lo = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_grant_lo = GW'(i);
                if (i > int'(last_grant)) begin
                    w_hit_hi   = 1'b1;
                    w_grant_hi = GW'(i);
                end
            end
        end
    end

    assign grant   = w_hit_hi ? w_grant_hi : w_grant_lo;
    assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-level arbiter feeding one uart_tx from NREQ byte streams, with stall timeout.
// Define UART_ARB_TAG_EN to prefix each message with a TAG_BASE+grant_id byte.
//
// state    | meaning
// ARB_IDLE | no owner; round-robin pick on any request
// ARB_TAG  | owner selected, tag byte on the output
// ARB_DATA | owner's bytes forwarded until last byte or timeout
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int          NREQ     = 4,
    parameter logic [15:0] TIMEOUT  = 16'hFFFF,
    parameter logic [7:0]  TAG_BASE = 8'h30
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*8-1:0]       req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output logic                    out_valid,
    output logic [7:0]              out_data,
    input  logic                    out_ready,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    timeout_pulse
);

    localparam int            GW       = $clog2(NREQ);
    localparam logic [15:0]   IDLE_TC  = TIMEOUT - 16'd1;
    localparam logic [GW-1:0] LAST_RST = GW'(NREQ - 1);

`ifdef UART_ARB_TAG_EN
    localparam arb_state_t GRANT_STATE = ARB_TAG;
`else
    localparam arb_state_t GRANT_STATE = ARB_DATA;
`endif

    logic [1:0]    r_rst_sync;
    logic          w_rst_n;
    arb_state_t    r_state;
    logic [GW-1:0] r_grant;
    logic [GW-1:0] r_last_grant;
    logic [15:0]   r_idle_cnt;
    logic [GW-1:0] w_pick;
    logic          w_any;
    logic [7:0]    w_bytes [NREQ];
    logic          w_own_valid;
    logic          w_own_last;
    logic          w_xfer;
    logic          w_timeout;

    // Assert asynchronously, release two clocks after resetn rises.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    for (genvar g = 0; g < NREQ; g++) begin : g_bytes
        assign w_bytes[g] = req_data[8*g +: 8];
    end

    uart_rr_pick #(
        .NREQ(NREQ)
    ) u_pick (
        .req       (req_valid),
        .last_grant(r_last_grant),
        .grant     (w_pick),
        .any_req   (w_any)
    );

    assign w_own_valid = req_valid[r_grant];
    assign w_own_last  = req_last[r_grant];
    assign w_xfer      = (r_state == ARB_DATA) && w_own_valid && out_ready;
    // A last-byte transfer on the terminal cycle wins over the timeout.
    assign w_timeout   = (r_state == ARB_DATA) && !w_xfer && (r_idle_cnt == IDLE_TC);

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= ARB_IDLE;
            r_grant      <= '0;
            r_last_grant <= LAST_RST;
            r_idle_cnt   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    r_idle_cnt <= '0;
                    if (w_any) begin
                        r_grant      <= w_pick;
                        r_last_grant <= w_pick;
                        r_state      <= GRANT_STATE;
                    end
                end
`ifdef UART_ARB_TAG_EN
                ARB_TAG: begin
                    if (out_ready) begin
                        r_state <= ARB_DATA;
                    end
                end
`endif
                ARB_DATA: begin
                    if (w_xfer) begin
                        r_idle_cnt <= '0;
                        if (w_own_last) begin
                            r_state <= ARB_IDLE;
                        end
                    end else if (w_timeout) begin
                        r_idle_cnt <= '0;
                        r_state    <= ARB_IDLE;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 16'd1;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        req_ready = '0;
        case (r_state)
            ARB_TAG: begin
                out_valid = 1'b1;
                out_data  = TAG_BASE + {{(8 - GW){1'b0}}, r_grant};
            end
            ARB_DATA: begin
                out_valid          = w_own_valid;
                out_data           = w_bytes[r_grant];
                req_ready[r_grant] = out_ready;
            end
            default: ;
        endcase
    end

    assign grant_id      = r_grant;
    assign busy          = (r_state != ARB_IDLE);
    assign timeout_pulse = w_timeout;

endmodule
